// File: rtl/hash_arbiter_pkg.sv
// Shared definitions for the hash arbiter slice: digest width, lane/result records and FSM states.
package hash_arbiter_pkg;

  localparam int DIGEST_W = 256;
  localparam int IDX_W    = 3;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  bytes;
  } packet_input;

  typedef struct packed {
    logic [DIGEST_W-1:0] digest;
    logic [IDX_W-1:0]    id;
  } packet_output;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRIME    = 3'd1,
    ST_STREAM   = 3'd2,
    ST_WAIT_DIG = 3'd3,
    ST_DELIVER  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/hash_arbiter_rr_select.sv
// Round-robin lane selector: picks the first requesting lane after last_grant, wrapping at NREQ.
module rr_select #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last_grant,
  output logic [2:0]      grant,
  output logic            any
);

  logic [7:0] req_pad_s;
  logic [3:0] sum_s;
  logic [2:0] idx_s;
  logic       hit_s;

  assign req_pad_s = 8'(req);

  // Scan from the farthest lane to the nearest so the nearest requester after last_grant wins.
  always_comb begin
    grant = 3'd0;
    any   = 1'b0;
    sum_s = 4'd0;
    idx_s = 3'd0;
    hit_s = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      sum_s = 4'(last_grant) + 4'(i);
      sum_s = (sum_s >= 4'(NREQ)) ? (sum_s - 4'(NREQ)) : sum_s;
      idx_s = sum_s[2:0];
      hit_s = req_pad_s[idx_s];
      grant = hit_s ? idx_s : grant;
      any   = any | hit_s;
    end
  end

endmodule

// File: rtl/hash_arbiter.sv
// Round-robin arbiter streaming one message at a time from NREQ lanes into a hash core.
// Define HASH_ARB_TIMEOUT_EN to compile in the STREAM stall watchdog (abort after TIMEOUT_CYCLES).
module hash_arbiter
  import hash_arbiter_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*64-1:0]    req_data,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*3-1:0]     req_bytes,
  output logic [NREQ-1:0]       req_ready,
  output logic                  core_reset,
  output logic [63:0]           core_in,
  output logic                  core_in_ready,
  output logic                  core_is_last,
  output logic [2:0]            core_byte_num,
  input  logic                  core_buffer_full,
  input  logic [DIGEST_W-1:0]   core_out,
  input  logic                  core_out_ready,
  output logic                  res_valid,
  output logic [2:0]            res_id,
  output logic [DIGEST_W-1:0]   res_digest,
  input  logic                  res_ack,
  output logic                  abort
);

  arb_state_e      state_r, state_nxt_s;
  logic [2:0]      last_grant_r;
  logic [2:0]      sel_grant_s;
  logic            sel_any_s;
  packet_input     lane_s;
  packet_output    res_r;
  logic            res_valid_r;
  logic            stream_s;
  logic            xfer_s;
  logic            timeout_s;
  logic [NREQ-1:0] ready_s;

  rr_select #(.NREQ(NREQ)) u_rr_select (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (sel_grant_s),
    .any        (sel_any_s)
  );

  // Lane mux and ready generation for the granted lane; reset forces everything quiet.
  always_comb begin
    lane_s   = '0;
    ready_s  = '0;
    stream_s = (state_r == ST_STREAM) && !reset;
    for (int i = 0; i < NREQ; i++) begin
      if (last_grant_r == 3'(i)) begin
        lane_s.data  = req_data[64*i +: 64];
        lane_s.last  = req_last[i];
        lane_s.bytes = req_bytes[3*i +: 3];
        ready_s[i]   = stream_s & ~core_buffer_full;
      end else begin
        ready_s[i]   = 1'b0;
      end
    end
    xfer_s = |(ready_s & req_valid);
  end

`ifdef HASH_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall_cnt_r;

  assign timeout_s = stream_s & ~xfer_s & ~core_buffer_full &
                     (stall_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Consecutive idle STREAM cycles; a full core pauses the count rather than clearing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= '0;
    end else if (!stream_s || xfer_s) begin
      stall_cnt_r <= '0;
    end else if (!core_buffer_full) begin
      stall_cnt_r <= stall_cnt_r + TO_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:     state_nxt_s = sel_any_s ? ST_PRIME : ST_IDLE;
      ST_PRIME:    state_nxt_s = ST_STREAM;
      ST_STREAM: begin
        if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else if (xfer_s && lane_s.last) begin
          state_nxt_s = ST_WAIT_DIG;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_WAIT_DIG: state_nxt_s = core_out_ready ? ST_DELIVER : ST_WAIT_DIG;
      ST_DELIVER:  state_nxt_s = res_ack ? ST_IDLE : ST_DELIVER;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // State, grant history and held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 3'(NREQ - 1);
      res_valid_r  <= 1'b0;
      res_r        <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && sel_any_s) begin
        last_grant_r <= sel_grant_s;
      end
      if (state_r == ST_WAIT_DIG && core_out_ready) begin
        res_r.digest <= core_out;
        res_r.id     <= last_grant_r;
        res_valid_r  <= 1'b1;
      end else if (state_r == ST_DELIVER && res_ack) begin
        res_valid_r  <= 1'b0;
      end
    end
  end

  assign req_ready     = ready_s;
  assign core_in_ready = xfer_s;
  assign core_in       = xfer_s ? lane_s.data  : 64'd0;
  assign core_is_last  = xfer_s ? lane_s.last  : 1'b0;
  assign core_byte_num = xfer_s ? lane_s.bytes : 3'd0;
  assign core_reset    = reset | (state_r == ST_PRIME) | timeout_s;
  assign abort         = timeout_s;
  assign res_valid     = res_valid_r;
  assign res_id        = res_r.id;
  assign res_digest    = res_r.digest;

endmodule

// File: doc/hash_arbiter.md
HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 SHALL have parameters: NREQ, 4, number of requesters (2..8); TIMEOUT_CYCLES, 256, stall limit used only when the watchdog is compiled in.
REQ-002 SHALL have ports, one per line:
 clk  in  1  single clock; all logic on its rising edge.
 reset  in  1  synchronous, active-high reset.
 req_valid  in  NREQ  requester i has a word on its lane.
 req_data  in  NREQ*64  lane i message word, bits [64*i+63:64*i].
 req_last  in  NREQ  lane i word is the final word of its message.
 req_bytes  in  NREQ*3  lane i valid-byte count of the final word (0..7).
 req_ready  out  NREQ  lane i word accepted this cycle.
 core_reset  out  1  one-cycle reset pulse to the hash core.
 core_in  out  64  word to the core.
 core_in_ready  out  1  core_in valid this cycle.
 core_is_last  out  1  final word marker.
 core_byte_num  out  3  final-word byte count.
 core_buffer_full  in  1  core cannot accept a word.
 core_out  in  DIGEST_W  core digest.
 core_out_ready  in  1  digest valid (level).
 res_valid  out  1  result held for consumer.
 res_id  out  3  requester index owning the result.
 res_digest  out  DIGEST_W  registered digest.
 res_ack  in  1  consumer accepts result.
 abort  out  1  one-cycle pulse when a message is aborted.

Function
REQ-003 SHALL implement FSM IDLE -> PRIME -> STREAM -> WAIT_DIG -> DELIVER -> IDLE.
REQ-004 IDLE: if any req_valid is high, SHALL grant by round-robin, searching from (last_grant+1) mod NREQ, register the grant, and enter PRIME the next cycle.
REQ-005 PRIME: SHALL last exactly one cycle, with core_reset=1 and all req_ready=0.
REQ-006 STREAM: req_ready[g] SHALL equal (granted g) AND NOT core_buffer_full, combinationally; all other lanes' req_ready SHALL be 0.
REQ-007 A transfer occurs when req_valid[g] and req_ready[g] are both high; core_in_ready SHALL equal that transfer, with core_in, core_is_last and core_byte_num passing lane g through combinationally (zero latency).
REQ-008 core_in, core_is_last and core_byte_num SHALL be 0 whenever core_in_ready=0.
REQ-009 A transfer with req_last=1 SHALL move the FSM to WAIT_DIG; a message whose length is a multiple of 8 bytes is carried as an extra word with req_bytes=0 and req_last=1, and SHALL be forwarded unchanged.
REQ-010 WAIT_DIG: on the first cycle core_out_ready=1, SHALL register core_out into res_digest and g into res_id, and enter DELIVER.
REQ-011 DELIVER: res_valid SHALL be 1; when res_ack=1, SHALL clear res_valid the next cycle and return to IDLE; res_digest and res_id SHALL hold stable until then.
REQ-012 last_grant SHALL update only on entry to PRIME; a requester that keeps req_valid high SHALL NOT be granted twice in a row while another lane is waiting.
REQ-013 Requests arriving during PRIME, STREAM, WAIT_DIG or DELIVER SHALL wait; at most one message is in flight.
REQ-014 core_buffer_full rising mid-message SHALL stall transfers with no word lost or duplicated.

Reset
REQ-015 On reset: FSM=IDLE, last_grant=NREQ-1 (first search starts at lane 0), res_valid=0, res_id=0, res_digest=0, abort=0, core_reset=1, all req_ready=0, core_in_ready=0.
REQ-016 Reset mid-message SHALL discard the message without producing a result; the core is reset by the core_reset=1 of REQ-015.

Configuration
REQ-017 Macro HASH_ARB_TIMEOUT_EN: when defined, a counter in STREAM SHALL count consecutive cycles with no transfer and core_buffer_full=0; it SHALL clear on every transfer.
REQ-018 When that counter reaches TIMEOUT_CYCLES, the block SHALL pulse abort and core_reset for one cycle, produce no result, and return to IDLE.
REQ-019 When HASH_ARB_TIMEOUT_EN is undefined, the counter SHALL be absent, abort SHALL be tied to 0, and STREAM SHALL wait indefinitely; the port list SHALL be identical in both builds.

Structure
REQ-020 DIGEST_W, the packet_input and packet_output typedefs, and the FSM state enum SHALL live in the shared defs package.
REQ-021 The round-robin selector SHALL be a sub-module rr_select (inputs: request vector, last_grant; outputs: grant index, any).

Verification
REQ-022 Single requester 0 sends "abc": 1 word, req_last=1, bytes=3 -> core_reset pulses once, 1 core word with core_byte_num=3, res_id=0, res_digest equals core_out.
REQ-023 Lanes 0..3 all valid in the same cycle after reset -> grant order 0,1,2,3,0; no core_in_ready overlap between messages.
REQ-024 16-byte message -> 3 core words, the third with is_last=1 and byte_num=0.
REQ-025 core_buffer_full held high 5 cycles mid-message -> req_ready=0 for exactly those cycles; word sequence at the core matches the source.
REQ-026 res_ack held low 20 cycles -> res_valid and res_digest stable for all 20 cycles; no new grant until ack.
REQ-027 With HASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the granted lane goes idle mid-message -> abort pulses on the 8th stall cycle, no res_valid, next lane granted.
